// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Multicycle controller for the shared 32-bit ALU. Takes one data-processing
//   op per request handshake, evaluates its ARM condition against NZCV, drives
//   the ALU for one cycle, captures the result and updates NZCV.
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   flush                    abort any in-flight op, return to IDLE
//   req_*                    op request (valid/ready, opcode, cond, S, Rn, Op2)
//   alu_inpa/inpb/cin/aluop  ALU drive (operands only non-zero during EXEC)
//   alu_result/n/z/c/v       ALU response, sampled at the end of EXEC
//   rsp_*                    result (valid/ready, result, writeback, error)
//   flags_nzcv               architectural NZCV register
module alu_op_sequencer #(
    parameter logic [3:0] FLAG_INIT = 4'b0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_opcode,
    input  logic [3:0]  req_cond,
    input  logic        req_s,
    input  logic [31:0] req_rn,
    input  logic [31:0] req_op2,
    output logic [31:0] alu_inpa,
    output logic [31:0] alu_inpb,
    output logic        alu_cin,
    output logic [2:0]  alu_aluop,
    input  logic [31:0] alu_result,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_wb,
    output logic        rsp_err,
    output logic [3:0]  flags_nzcv
);

    typedef enum logic [1:0] {IDLE, EVAL, EXEC, RESP} state_t;

    localparam logic [3:0] OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6;
    localparam logic [3:0] OP_CMP = 4'd10, OP_ORR = 4'd12, OP_MOV = 4'd13;

    state_t      state;
    logic        eval_ph;   // EVAL is two cycles: decide, then launch
    logic        pass_q;    // condition passed and opcode supported
    logic        unsup_q;
    logic [3:0]  op_q;
    logic [3:0]  cond_q;
    logic        s_q;
    logic [31:0] rn_q;
    logic [31:0] op2_q;

    // opcode decode of the latched op
    logic [2:0] dec_aluop;
    logic       dec_sup;
    logic       is_logic;
    logic       is_sub;
    logic       is_cmp;

    always_comb begin
        dec_aluop = 3'b000;
        dec_sup   = 1'b1;
        case (op_q)
            OP_AND:  dec_aluop = 3'b011;
            OP_EOR:  dec_aluop = 3'b111;
            OP_SUB:  dec_aluop = 3'b000;
            OP_ADD:  dec_aluop = 3'b001;
            OP_ADC:  dec_aluop = 3'b101;
            OP_SBC:  dec_aluop = 3'b100;
            OP_CMP:  dec_aluop = 3'b000;
            OP_ORR:  dec_aluop = 3'b010;
            OP_MOV:  dec_aluop = 3'b001;
            default: dec_sup   = 1'b0;
        endcase
    end

    assign is_logic = (op_q == OP_AND) || (op_q == OP_EOR) || (op_q == OP_ORR);
    assign is_sub   = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CMP);
    assign is_cmp   = (op_q == OP_CMP);

    // ARM condition evaluation against the current NZCV
    logic fn, fz, fc, fv, cond_ok;
    assign {fn, fz, fc, fv} = flags_nzcv;

    always_comb begin
        cond_ok = 1'b0;
        case (cond_q)
            4'd0:  cond_ok = fz;
            4'd1:  cond_ok = ~fz;
            4'd2:  cond_ok = fc;
            4'd3:  cond_ok = ~fc;
            4'd4:  cond_ok = fn;
            4'd5:  cond_ok = ~fn;
            4'd6:  cond_ok = fv;
            4'd7:  cond_ok = ~fv;
            4'd8:  cond_ok = fc & ~fz;
            4'd9:  cond_ok = ~fc | fz;
            4'd10: cond_ok = (fn == fv);
            4'd11: cond_ok = (fn != fv);
            4'd12: cond_ok = ~fz & (fn == fv);
            4'd13: cond_ok = fz | (fn != fv);
            4'd14: cond_ok = 1'b1;
            default: cond_ok = 1'b0;  // NV never executes
        endcase
    end

    // Next NZCV from the ALU response. Subtraction carry is the ALU's raw
    // borrow, inverted to ARM's not-borrow; subtract overflow is computed here
    // from the operands actually driven, since the ALU's V is add-only.
    logic [3:0] new_flags;
    logic       sub_v;
    assign sub_v = (alu_inpa[31] ^ alu_inpb[31]) & (alu_inpa[31] ^ alu_result[31]);

    always_comb begin
        new_flags = {alu_n, alu_z, flags_nzcv[1:0]};
        if (is_sub)
            new_flags[1:0] = {~alu_c, sub_v};
        else if (!is_logic)
            new_flags[1:0] = {alu_c, alu_v};
    end

    assign req_ready = (state == IDLE);
    assign alu_cin   = flags_nzcv[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            eval_ph    <= 1'b0;
            pass_q     <= 1'b0;
            unsup_q    <= 1'b0;
            op_q       <= '0;
            cond_q     <= '0;
            s_q        <= 1'b0;
            rn_q       <= '0;
            op2_q      <= '0;
            alu_inpa   <= '0;
            alu_inpb   <= '0;
            alu_aluop  <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_wb     <= 1'b0;
            rsp_err    <= 1'b0;
            flags_nzcv <= FLAG_INIT;
        end else if (flush) begin
            // abort: nothing committed, ALU released, response withdrawn
            state     <= IDLE;
            eval_ph   <= 1'b0;
            alu_inpa  <= '0;
            alu_inpb  <= '0;
            alu_aluop <= '0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_opcode;
                        cond_q  <= req_cond;
                        s_q     <= req_s;
                        rn_q    <= req_rn;
                        op2_q   <= req_op2;
                        eval_ph <= 1'b0;
                        state   <= EVAL;
                    end
                end
                EVAL: begin
                    if (!eval_ph) begin
                        pass_q  <= cond_ok & dec_sup;
                        unsup_q <= ~dec_sup;
                        eval_ph <= 1'b1;
                    end else if (pass_q) begin
                        alu_inpa  <= (op_q == OP_MOV) ? 32'd0 : rn_q;
                        alu_inpb  <= op2_q;
                        alu_aluop <= dec_aluop;
                        state     <= EXEC;
                    end else begin
                        rsp_valid  <= 1'b1;
                        rsp_result <= '0;
                        rsp_wb     <= 1'b0;
                        rsp_err    <= unsup_q;
                        state      <= RESP;
                    end
                end
                EXEC: begin
                    rsp_valid  <= 1'b1;
                    rsp_result <= alu_result;
                    rsp_wb     <= ~is_cmp;
                    rsp_err    <= 1'b0;
                    if (is_cmp || s_q)
                        flags_nzcv <= new_flags;
                    alu_inpa   <= '0;
                    alu_inpb   <= '0;
                    alu_aluop  <= '0;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
